seq_sub_16: RTL

SEQ_SUB_16 -- requirements
Module: seq_sub_16

---
 rtl/seq_sub_pkg.sv | 16 +
 rtl/seq_sub_16_cla4_slice.sv | 39 +++
 rtl/seq_sub_16.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/seq_sub_pkg.sv
// seq_sub_pkg: shared parameters and state type
// for the slice-serial subtractor.
package seq_sub_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;
    localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;
    localparam int CNT_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/seq_sub_16_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder
// with carries built as nand-of-nand sum-of-products.
module cla4_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o,
    output logic       g_o,
    output logic       p_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // bit generate/propagate and lookahead carries
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = c_i;
        c[1] = ~(~g[0] & ~(p[0] & c_i));
        c[2] = ~(~g[1]
               & ~(p[1] & g[0])
               & ~(p[1] & p[0] & c_i));
        c[3] = ~(~g[2]
               & ~(p[2] & g[1])
               & ~(p[2] & p[1] & g[0])
               & ~(p[2] & p[1] & p[0] & c_i));
        g_o  = ~(~g[3]
               & ~(p[3] & g[2])
               & ~(p[3] & p[2] & g[1])
               & ~(p[3] & p[2] & p[1] & g[0]));
        p_o  = &p;
        c_o  = ~(~g_o & ~(p_o & c_i));
        s_o  = p ^ c;
    end

endmodule

// File: rtl/seq_sub_16.sv
// seq_sub_16: slice-serial subtractor, a - b - bin
// computed as a + ~b + ~bin, one 4-bit slice per cycle.
module seq_sub_16
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int NS  = WIDTH / SLICE;
    localparam int CW  = (NS > 1) ? $clog2(NS) : 1;
    localparam int SH  = $clog2(SLICE);
    localparam int MSB = WIDTH - 1;

    localparam logic [CW-1:0] LAST = CW'(NS - 1);
    localparam logic [WIDTH-1:0] MASK =
        WIDTH'({SLICE{1'b1}});

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [CW+SH-1:0] off;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic             sl_co;
    logic             sl_g;
    logic             sl_p;
    logic             sl_c;

    // select the slice addressed by the counter
    always_comb begin
        off  = {cnt_q, {SH{1'b0}}};
        sl_a = SLICE'(a_q >> off);
        sl_b = SLICE'(nb_q >> off);
    end

    cla4_slice u_slice (
        .a_i (sl_a),
        .b_i (sl_b),
        .c_i (c_q),
        .s_o (sl_s),
        .c_o (sl_co),
        .g_o (sl_g),
        .p_o (sl_p)
    );

    // FSM next state and datapath next values
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        sl_c    = ~(~sl_g & ~(sl_p & c_q));
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    nb_d    = ~b;
                    c_d     = ~bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = (res_q & ~(MASK << off))
                      | (WIDTH'(sl_s) << off);
                c_d   = sl_c;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    bout_d  = ~sl_co;
                    ovf_d   = (a_q[MSB] == nb_q[MSB])
                            && (sl_s[SLICE-1] != a_q[MSB]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    res_d   = '0;
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    // outputs depend on registers only; the partial
    // result is hidden until the operation completes
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        d         = out_valid ? res_q : '0;
        bout      = bout_q;
        ovf       = ovf_q;
    end

endmodule
